// File: rtl/g2b_pkg.sv
// Shared types and constants for the round-robin Gray-to-binary scheduler.
package g2b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int unsigned N_DEF    = 6;
  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned CNTW_DEF = 16;

  // Ceiling log2, used to size the requester index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/g2b_rr_scheduler_core.sv
// Combinational Gray-to-binary converter shared by all requesters.
module g2b_core #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // bin[i] is the parity of gray[N-1:i], the unrolled form of the XOR chain.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/g2b_rr_scheduler.sv
// Round-robin scheduler sharing one Gray-to-binary converter among NREQ requesters.
module g2b_rr_scheduler
  import g2b_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = clog2(NREQ),
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*N-1:0]  req_gray,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  output logic [N-1:0]       out_bin,
  output logic [IDW-1:0]     out_id,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNTW-1:0]    done_count
);

  localparam int unsigned SW = IDW + 1;

  state_t          state;
  logic [N-1:0]    gray_q;
  logic [N-1:0]    bin_q;
  logic [N-1:0]    bin_c;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  start;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  grant;
  logic [NREQ-1:0] rot;
  logic [SW-1:0]   sum;
  logic            any_valid;

  // Rotate so the requester after last_grant sits at bit 0, pick lowest, rotate back.
  always_comb begin
    start = (last_grant == IDW'(NREQ - 1)) ? '0 : last_grant + IDW'(1);
    rot   = (req_valid >> start) | (req_valid << (NREQ - 32'(start)));
    pick  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (rot[k]) pick = IDW'(k);
    end
    sum = SW'(pick) + SW'(start);
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    grant = sum[IDW-1:0];
  end

  assign any_valid = |req_valid;
  assign req_ready = (!rst && state == IDLE && any_valid) ? (NREQ'(1) << grant) : '0;
  assign out_bin   = bin_q;
  assign out_id    = id_q;

  g2b_core #(.N(N)) u_core (
    .gray (gray_q),
    .bin  (bin_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gray_q     <= '0;
      bin_q      <= '0;
      id_q       <= '0;
      last_grant <= IDW'(NREQ - 1);
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gray_q     <= req_gray[grant*N +: N];
            id_q       <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          bin_q     <= bin_c;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            done_count <= done_count + CNTW'(1);
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g2b_rr_scheduler.sv
// Self-checking bench for g2b_rr_scheduler: vector table plus scoreboard-checked sequences.
module tb_g2b_rr_scheduler;

  localparam int unsigned N    = 6;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct {
    logic [NREQ-1:0]   valid;
    logic [NREQ*N-1:0] gray;
    logic [NREQ-1:0]   ready;
    logic [N-1:0]      bin;
    logic [IDW-1:0]    id;
  } vec_t;

  typedef struct packed {
    logic [N-1:0]   bin;
    logic [IDW-1:0] id;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_gray;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [N-1:0]      out_bin;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic              busy;
  logic [15:0]       done_count;

  logic [NREQ-1:0]   w_req_ready;
  logic              w_out_valid;
  logic [N-1:0]      w_out_bin;
  logic [IDW-1:0]    w_out_id;
  logic              w_busy;
  logic [3:0]        w_done;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   hs_count = 0;
  exp_t sb[$];
  vec_t vecs[7];

  g2b_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .out_valid(out_valid), .out_bin(out_bin),
    .out_id(out_id), .out_ready(out_ready), .busy(busy), .done_count(done_count)
  );

  g2b_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW), .CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(w_req_ready), .out_valid(w_out_valid), .out_bin(w_out_bin),
    .out_id(w_out_id), .out_ready(out_ready), .busy(w_busy), .done_count(w_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [N-1:0] g2b_ref(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_bin", 32'(out_bin), 32'(e.bin));
        check("out_id", 32'(out_id), 32'(e.id));
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] b, input logic [IDW-1:0] id);
    exp_t e;
    e.bin = b;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic wait_hs(input int n, input int bound);
    int target;
    target = hs_count + n;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk); #1;
      if (hs_count >= target) break;
    end
    check("handshakes", 32'(hs_count), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '1;
    sb.delete();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic apply(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] g,
                       input logic [NREQ-1:0] er, input logic [N-1:0] eb,
                       input logic [IDW-1:0] eid);
    @(posedge clk); #1;
    req_valid = v;
    req_gray  = g;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check("req_ready", 32'(req_ready), 32'(er));
    push_exp(eb, eid);
    @(posedge clk); #1;
    req_valid = '0;
    wait_hs(1, 10);
  endtask

  initial begin
    int hs0;
    logic [N-1:0] gw[NREQ];

    vecs[0] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'b100000}, 4'b0001, 6'b111111, 2'd0};
    vecs[1] = '{4'b0010, {6'd0, 6'd0, 6'b110000, 6'd0}, 4'b0010, 6'b100000, 2'd1};
    vecs[2] = '{4'b1000, {6'b000001, 6'd0, 6'd0, 6'd0}, 4'b1000, 6'b000001, 2'd3};
    vecs[3] = '{4'b0100, {6'd0, 6'b000000, 6'd0, 6'd0}, 4'b0100, 6'b000000, 2'd2};
    vecs[4] = '{4'b1011, {6'b111111, 6'd0, 6'b001100, 6'b000111}, 4'b1000, 6'b101010, 2'd3};
    vecs[5] = '{4'b0110, {6'd0, 6'b111000, 6'b011011, 6'd0}, 4'b0010, 6'b010010, 2'd1};
    vecs[6] = '{4'b0011, {6'd0, 6'd0, 6'b110011, 6'b000110}, 4'b0001, 6'b000100, 2'd0};

    rst = 1'b0;
    req_valid = '1;
    req_gray = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_bin", 32'(out_bin), 32'd0);
    check("reset_out_id", 32'(out_id), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done_count", 32'(done_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // Single request on requester 2: one-cycle ready, result two cycles later.
    hs0 = hs_count;
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_gray  = {6'd0, 6'b010101, 6'd0, 6'd0};
    @(negedge clk);
    check("single_req_ready", 32'(req_ready), 32'b0100);
    push_exp(6'b011001, 2'd2);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("single_ready_drop", 32'(req_ready), 32'd0);
    check("single_conv_valid", 32'(out_valid), 32'd0);
    check("single_conv_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("single_hs", 32'(hs_count), 32'(hs0 + 1));
    check("single_done_count", 32'(done_count), 32'd1);
    check("single_valid_low", 32'(out_valid), 32'd0);

    // Conversion vectors and round-robin picks with several valids.
    for (int i = 0; i < 7; i++)
      apply(vecs[i].valid, vecs[i].gray, vecs[i].ready, vecs[i].bin, vecs[i].id);

    // Fairness: all requesters continuously valid for 8 conversions.
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      gw[i] = N'($urandom_range(0, 63));
      req_gray[i*N +: N] = gw[i];
    end
    for (int i = 0; i < 8; i++) push_exp(g2b_ref(gw[i % NREQ]), IDW'(i % NREQ));
    @(posedge clk); #1;
    req_valid = '1;
    wait_hs(8, 60);
    req_valid = '0;
    check("fair_queue_empty", 32'(sb.size()), 32'd0);
    check("fair_done_count", 32'(done_count), 32'd8);

    // Backpressure: hold OUT for 10 cycles with other requesters waiting.
    @(posedge clk); #1;
    out_ready = 1'b0;
    req_valid = 4'b0010;
    req_gray  = {6'b000111, 6'b010000, 6'b101101, 6'b111111};
    @(negedge clk);
    check("bp_req_ready", 32'(req_ready), 32'b0010);
    push_exp(6'b110110, 2'd1);
    @(posedge clk); #1;
    req_valid = 4'b1101;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_bin", 32'(out_bin), 32'b110110);
      check("bp_out_id", 32'(out_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    check("bp_done_count", 32'(done_count), 32'd9);
    repeat (3) @(posedge clk);
    #1;
    check("bp_done_stable", 32'(done_count), 32'd9);
    check("bp_queue_empty", 32'(sb.size()), 32'd0);

    // Reset asserted asynchronously while in CONV.
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_gray  = {6'd0, 6'b000011, 6'd0, 6'b011110};
    @(negedge clk);
    check("rmid_req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    check("rmid_conv_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rmid_out_valid", 32'(out_valid), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_done_count", 32'(done_count), 32'd0);
    check("rmid_out_bin", 32'(out_bin), 32'd0);
    check("rmid_out_id", 32'(out_id), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    check("rmid_first_winner", 32'(req_ready), 32'b0001);
    push_exp(6'b010100, 2'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_hs(1, 10);
    check("rmid_done_after", 32'(done_count), 32'd1);

    // Counter wrap on the 4-bit counter instance after 17 conversions.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic [NREQ*N-1:0] g;
      logic [N-1:0]      gv;
      gv = N'(i * 5);
      g  = '0;
      g[(i % NREQ)*N +: N] = gv;
      apply(NREQ'(1) << (i % NREQ), g, NREQ'(1) << (i % NREQ), g2b_ref(gv), IDW'(i % NREQ));
    end
    check("wrap_w_done", 32'(w_done), 32'd1);
    check("wrap_done_count", 32'(done_count), 32'd17);
    check("wrap_w_out_bin", 32'(w_out_bin), 32'(g2b_ref(N'(16 * 5))));
    check("wrap_w_out_id", 32'(w_out_id), 32'd0);
    check("wrap_w_idle", 32'({w_out_valid, w_busy, w_req_ready}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/g2b_rr_scheduler.md
# g2b_rr_scheduler

Round-robin scheduler that shares one Gray-to-binary conversion datapath among `NREQ` requesters. Each requester offers a Gray word over a valid/ready handshake. The scheduler grants one requester at a time, registers the word, converts it and presents the binary result tagged with the requester index. It sits between the Gray-coded pointer/encoder sources and their binary consumers, so only one converter instance is needed.

## Interface
- `N`, default 6: data width in bits (N ≥ 2).
- `NREQ`, default 4: number of requesters (2..8).
- `IDW`, default 2: requester-index width, equal to clog2(NREQ).
- `CNTW`, default 16: width of the completed-conversion counter.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester valid.
- `req_gray` in NREQ*N: requester i's word is at bits [i*N +: N].
- `req_ready` out NREQ: one-hot accept strobe; all zero when not accepting.
- `out_valid` out 1: result valid.
- `out_bin` out N: converted binary word.
- `out_id` out IDW: index of the requester that produced the result.
- `out_ready` in 1: downstream accept.
- `busy` out 1: high in any state other than IDLE.
- `done_count` out CNTW: number of completed output handshakes; wraps modulo 2^CNTW.

## Operation
- FSM states are IDLE, CONV and OUT. Reset state is IDLE.
- **IDLE**
  - Round-robin search starts at `last_grant+1` mod NREQ and picks the first asserted `req_valid`.
  - `req_ready[g]=1` is driven combinationally for that winner only.
  - On the edge with any `req_valid` high: capture `req_gray[g]` into `gray_q`, capture `g` into `id_q`, set `last_grant<=g`, go to CONV.
  - If no `req_valid` is high: stay in IDLE; `last_grant` is unchanged.
- **CONV**
  - `bin_q <= g2b(gray_q)`, where bin[N-1]=g[N-1] and bin[i]=g[i]^bin[i+1].
  - Go to OUT.
- **OUT**
  - `out_valid=1`. `out_bin=bin_q` and `out_id=id_q` are held stable.
  - On `out_ready=1`: increment `done_count` and go to IDLE.
  - Otherwise hold all outputs; there is no timeout.
- `req_ready` is all zero in CONV and OUT. Requests that arrive meanwhile wait; requesters must hold `req_valid` and data until granted.
- A requester that deasserts `req_valid` before being granted is simply skipped. There is no latching of requests.
- Reset values:
  - `out_valid=0`, `out_bin=0`, `out_id=0`, `busy=0`, `done_count=0`, `req_ready=0`.
  - `last_grant=NREQ-1`, so requester 0 has first priority.
- Reset asserted mid-operation discards the in-flight word immediately (asynchronous). No output handshake completes and `done_count` is not incremented.

## Timing
- Accept edge at cycle k: `out_valid` is high from edge k+2.
- Zero-stall throughput is one conversion per 3 cycles (IDLE→CONV→OUT→IDLE).
- `out_ready` sampled high in OUT at edge m: `out_valid` is low after edge m. The next accept can occur at edge m+1 at the earliest.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. The worst-case wait is (NREQ-1) conversions plus the current one.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, `last_grant` and the state.

## Structure
- Shared package `g2b_pkg` holds:
  - the state enum `{IDLE, CONV, OUT}`;
  - the default width constants;
  - a `clog2` helper for `IDW`.
- One sub-module, `g2b_core`: parameterised purely combinational Gray-to-binary converter (N in, N out, XOR chain). It is instantiated once between `gray_q` and `bin_q`.
- Round-robin arbitration (a rotate, priority-pick, rotate-back scheme) stays inside the top module.

## Test plan
- **Single request, path and latency.** Requester 2 presents gray 6'b010101 with out_ready=1. Required: `req_ready=4'b0100` for one cycle; 2 cycles later `out_valid=1`, `out_bin=6'b011001`, `out_id=2`; `done_count=1`.
- **Conversion vectors.** Check 6'b100000→111111, 6'b110000→100000, 6'b000001→000001 and 6'b000000→000000, each on a different requester.
- **Round-robin fairness.** All 4 requesters hold valid for 8 conversions after reset. Required: `out_id` sequence 0,1,2,3,0,1,2,3; each result matches that requester's data.
- **Backpressure.** Hold out_ready=0 for 10 cycles in OUT. Required: `out_valid`, `out_bin` and `out_id` stay stable; `req_ready` stays 0; `busy` stays 1. Release out_ready: one handshake, `done_count` increments by exactly 1.
- **Reset mid-operation.** Assert rst asynchronously during CONV. Required: outputs go to their reset values immediately and the counter is unchanged from 0. After release, requester 0 wins first.
- **Counter wrap.** With CNTW=4, complete 17 conversions. Required: `done_count=1`.
